// File: rtl/alu_issue_ctrl.sv
// Three-state issue/writeback sequencer feeding a combinational ALU from an internal register file.
// Optional performance counters are enabled by defining ALU_ISSUE_PERF_EN.
module alu_issue_ctrl #(
  parameter int unsigned NREGS     = 16,
  parameter logic [3:0]  RST_FLAGS = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [31:0] alu_inf,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_r,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_c,
  input  logic        alu_v,
  output logic        resp_valid,
  output logic [3:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic        resp_wen,
  output logic        resp_err,
  output logic [3:0]  flags_nzcv,
  input  logic [3:0]  dbg_raddr,
  output logic [31:0] dbg_rdata
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_skipped,
  output logic [31:0] perf_illegal
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t      state, state_n;
  logic [31:0] rf [NREGS];
  logic [3:0]  rd_q, op_q, cap_f;
  logic        s_q, pass_q;
  logic [31:0] cap_r;
  logic        is_alu, legal, rd_ok, wen, fwen;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    logic res;
    {n, z, c, v} = f;
    case (cond)
      4'h0:    res = z;
      4'h1:    res = !z;
      4'h2:    res = c;
      4'h3:    res = !c;
      4'h4:    res = n;
      4'h5:    res = !n;
      4'h6:    res = v;
      4'h7:    res = !v;
      4'h8:    res = c && !z;
      4'h9:    res = !c || z;
      4'hA:    res = (n == v);
      4'hB:    res = (n != v);
      4'hC:    res = !z && (n == v);
      4'hD:    res = z || (n != v);
      4'hE:    res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Indices beyond NREGS read as zero and are never written.
  function automatic logic [31:0] rf_read(input logic [3:0] idx);
    logic [31:0] val;
    val = '0;
    if (32'(idx) < NREGS) val = rf[idx];
    return val;
  endfunction

  assign is_alu = !op_q[3];
  assign legal  = is_alu || (op_q == 4'b1000);
  assign rd_ok  = 32'(rd_q) < NREGS;
  assign wen    = is_alu && pass_q && rd_ok;
  assign fwen   = pass_q && ((is_alu && s_q) || (op_q == 4'b1000));

  always_comb dbg_rdata = rf_read(dbg_raddr);

  always_comb begin
    state_n    = state;
    in_ready   = 1'b0;
    resp_valid = 1'b0;
    resp_rd    = '0;
    resp_data  = '0;
    resp_wen   = 1'b0;
    resp_err   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = EXEC;
      end
      EXEC: state_n = WB;
      WB: begin
        resp_valid = 1'b1;
        resp_rd    = rd_q;
        resp_data  = legal ? cap_r : '0;
        resp_wen   = wen;
        resp_err   = !legal;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      alu_inf    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rd_q       <= '0;
      op_q       <= '0;
      s_q        <= 1'b0;
      pass_q     <= 1'b0;
      cap_r      <= '0;
      cap_f      <= '0;
      flags_nzcv <= RST_FLAGS;
      for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
`ifdef ALU_ISSUE_PERF_EN
      perf_issued  <= '0;
      perf_skipped <= '0;
      perf_illegal <= '0;
`endif
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        alu_inf <= in_instr;
        alu_a   <= rf_read(in_instr[18:15]);
        alu_b   <= rf_read(in_instr[14:11]);
        rd_q    <= in_instr[22:19];
        op_q    <= in_instr[27:24];
        s_q     <= in_instr[23];
        pass_q  <= cond_pass(in_instr[31:28], flags_nzcv);
      end
      if (state == EXEC) begin
        cap_r <= alu_r;
        cap_f <= {alu_n, alu_z, alu_c, alu_v};
      end
      if (state == WB) begin
        if (wen)  rf[rd_q]   <= cap_r;
        if (fwen) flags_nzcv <= cap_f;
`ifdef ALU_ISSUE_PERF_EN
        perf_issued <= perf_issued + 32'd1;
        if (legal && !pass_q) perf_skipped <= perf_skipped + 32'd1;
        if (!legal)           perf_illegal <= perf_illegal + 32'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Table-driven bench for alu_issue_ctrl: the bench plays the ALU and scoreboards each writeback.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready;
  logic [31:0] in_instr, alu_inf, alu_a, alu_b, alu_r, resp_data, dbg_rdata;
  logic        alu_n, alu_z, alu_c, alu_v;
  logic        resp_valid, resp_wen, resp_err;
  logic [3:0]  resp_rd, flags_nzcv, dbg_raddr;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_issued, perf_skipped, perf_illegal;
  int          p_iss, p_skip, p_ill;
`endif

  always #5 clk = ~clk;

  alu_issue_ctrl #(.NREGS(16), .RST_FLAGS(4'b0000)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .alu_inf(alu_inf), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_data(resp_data),
    .resp_wen(resp_wen), .resp_err(resp_err), .flags_nzcv(flags_nzcv),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
`ifdef ALU_ISSUE_PERF_EN
    , .perf_issued(perf_issued), .perf_skipped(perf_skipped), .perf_illegal(perf_illegal)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] r;
    logic [3:0]  nzcv;
    logic        pass;
    logic        wen;
    logic        err;
    logic [31:0] data;
    logic [3:0]  flags;
  } vec_t;

  vec_t        vecs [28];
  vec_t        sb_q [$];
  vec_t        pend, mv;
  logic [31:0] rf_m [16];
  logic [3:0]  flags_m;
  int          errors = 0, checks = 0, acc_count = 0, cur_idx = 0;
  logic        exec_now, wb_now, acc_prev, post_wb;

  function automatic logic [31:0] ins(input logic [3:0] cond, input logic [3:0] op, input logic s,
                                      input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm);
    return {cond, op, s, rd, rn, rm, 11'b0};
  endfunction

  function automatic logic [31:0] movn(input logic [3:0] rd, input logic [15:0] imm);
    return {4'hE, 4'h7, 1'b0, rd, imm, 3'b0};
  endfunction

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] r, input logic [3:0] nzcv,
                              input logic pass, input logic wen, input logic err,
                              input logic [31:0] data, input logic [3:0] flags);
    vec_t v;
    v.instr = instr; v.r = r; v.nzcv = nzcv; v.pass = pass;
    v.wen = wen; v.err = err; v.data = data; v.flags = flags;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Negedge monitor: tracks EXEC/WB phase from observed accepts, plays the ALU, checks writeback.
  task mon_loop;
    forever begin
      @(negedge clk);
      if (rst) begin
        exec_now = 1'b0; wb_now = 1'b0; acc_prev = 1'b0; post_wb = 1'b0;
        sb_q.delete();
        flags_m = 4'b0000;
        for (int i = 0; i < 16; i++) rf_m[i] = '0;
`ifdef ALU_ISSUE_PERF_EN
        p_iss = 0; p_skip = 0; p_ill = 0;
`endif
      end else begin
        wb_now   = exec_now;
        exec_now = acc_prev;
        chk("in_ready", 32'(in_ready), 32'(!(exec_now || wb_now)));
        chk("resp_valid", 32'(resp_valid), 32'(wb_now));
        if (post_wb) begin
          chk("dbg_after_wb", dbg_rdata, rf_m[dbg_raddr]);
          chk("flags_after_wb", 32'(flags_nzcv), 32'(flags_m));
          post_wb = 1'b0;
        end
        if (wb_now) begin
          if (sb_q.size() == 0) begin
            chk("sb_nonempty", 32'(sb_q.size()), 32'd1);
          end else begin
            mv = sb_q.pop_front();
            chk("resp_rd", 32'(resp_rd), 32'(mv.instr[22:19]));
            chk("resp_wen", 32'(resp_wen), 32'(mv.wen));
            chk("resp_err", 32'(resp_err), 32'(mv.err));
            chk("resp_data", resp_data, mv.data);
            chk("flags_in_wb", 32'(flags_nzcv), 32'(flags_m));
            chk("dbg_old_in_wb", dbg_rdata, rf_m[mv.instr[22:19]]);
            if (mv.wen) rf_m[mv.instr[22:19]] = mv.data;
            flags_m = mv.flags;
            post_wb = 1'b1;
`ifdef ALU_ISSUE_PERF_EN
            p_iss++;
            if (mv.err) p_ill++;
            else if (!mv.pass) p_skip++;
`endif
          end
        end
        if (exec_now) begin
          chk("alu_inf", alu_inf, pend.instr);
          chk("alu_a", alu_a, rf_m[pend.instr[18:15]]);
          chk("alu_b", alu_b, rf_m[pend.instr[14:11]]);
          alu_r = pend.r;
          {alu_n, alu_z, alu_c, alu_v} = pend.nzcv;
          dbg_raddr = pend.instr[22:19];
        end else begin
          alu_r = $urandom;
          {alu_n, alu_z, alu_c, alu_v} = 4'($urandom);
        end
        acc_prev = in_valid && in_ready;
        if (acc_prev) begin
          pend = vecs[cur_idx];
          sb_q.push_back(pend);
          acc_count++;
        end
      end
    end
  endtask

  task automatic issue(input int idx, input bit keep_valid);
    int n0;
    bit got;
    n0 = acc_count;
    got = 1'b0;
    cur_idx = idx;
    in_instr = vecs[idx].instr;
    in_valid = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk); #1;
      if (acc_count != n0) got = 1'b1;
    end
    if (!got) chk("accept_timeout", 32'(idx), 32'hFFFF_FFFF);
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic run_one(input int idx);
    issue(idx, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("resp_seen", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    vecs[0]  = mk(movn(4'd1, 16'hFFFA),                      32'd5,  4'h0, 1, 1, 0, 32'd5,  4'h0);
    vecs[1]  = mk(movn(4'd2, 16'hFFF8),                      32'd7,  4'h0, 1, 1, 0, 32'd7,  4'h0);
    vecs[2]  = mk(ins(4'hE, 4'h0, 1, 4'd3, 4'd1, 4'd2),      32'd12, 4'h0, 1, 1, 0, 32'd12, 4'h0);
    vecs[3]  = mk(ins(4'hE, 4'h8, 0, 4'd0, 4'd1, 4'd1),      32'd0,  4'h6, 1, 0, 0, 32'd0,  4'h6);
    vecs[4]  = mk(ins(4'h0, 4'h0, 0, 4'd4, 4'd1, 4'd3),      32'd17, 4'h0, 1, 1, 0, 32'd17, 4'h6);
    vecs[5]  = mk(ins(4'h1, 4'h0, 0, 4'd5, 4'd1, 4'd2),      32'd12, 4'h0, 0, 0, 0, 32'd12, 4'h6);
    vecs[6]  = mk(ins(4'hE, 4'hA, 1, 4'd6, 4'd1, 4'd2), 32'h0000_DEAD, 4'hF, 1, 0, 1, 32'd0, 4'h6);
    vecs[7]  = mk(ins(4'hE, 4'h1, 0, 4'd7, 4'd2, 4'd1),      32'd2,  4'h9, 1, 1, 0, 32'd2,  4'h6);
    vecs[8]  = mk(ins(4'hE, 4'h0, 1, 4'd8, 4'd3, 4'd3), 32'h8000_0000, 4'h9, 1, 1, 0, 32'h8000_0000, 4'h9);
    vecs[9]  = mk(ins(4'hA, 4'h0, 0, 4'd9, 4'd1, 4'd1),      32'd3,  4'h0, 1, 1, 0, 32'd3,  4'h9);
    vecs[10] = mk(ins(4'hB, 4'h0, 1, 4'd10, 4'd1, 4'd1),     32'd4,  4'h4, 0, 0, 0, 32'd4,  4'h9);
    vecs[11] = mk(ins(4'hF, 4'h8, 1, 4'd0, 4'd2, 4'd2),      32'd9,  4'h4, 0, 0, 0, 32'd9,  4'h9);
    vecs[12] = mk(ins(4'hE, 4'hF, 0, 4'd11, 4'd1, 4'd2),     32'd1,  4'h0, 1, 0, 1, 32'd0,  4'h9);
    vecs[13] = mk(ins(4'hE, 4'h0, 1, 4'd15, 4'd4, 4'd5), 32'hFFFF_FFFF, 4'h2, 1, 1, 0, 32'hFFFF_FFFF, 4'h2);
    vecs[14] = mk(ins(4'h8, 4'h0, 0, 4'd11, 4'd15, 4'd1), 32'h1234, 4'h0, 1, 1, 0, 32'h1234, 4'h2);
    vecs[15] = mk(ins(4'h9, 4'h0, 0, 4'd12, 4'd1, 4'd2),     32'h55, 4'h0, 0, 0, 0, 32'h55, 4'h2);
    vecs[16] = mk(ins(4'hE, 4'h8, 1, 4'd0, 4'd15, 4'd15),    32'd0,  4'h0, 1, 0, 0, 32'd0,  4'h0);
    vecs[17] = mk(ins(4'h4, 4'h0, 0, 4'd13, 4'd1, 4'd2),     32'd6,  4'h0, 0, 0, 0, 32'd6,  4'h0);
    vecs[18] = mk(ins(4'h5, 4'h0, 1, 4'd13, 4'd1, 4'd2),     32'd6,  4'h8, 1, 1, 0, 32'd6,  4'h8);
    vecs[19] = mk(ins(4'hC, 4'h0, 0, 4'd14, 4'd1, 4'd2),     32'd7,  4'h0, 0, 0, 0, 32'd7,  4'h8);
    vecs[20] = mk(ins(4'hD, 4'h0, 0, 4'd14, 4'd1, 4'd2),     32'd7,  4'h0, 1, 1, 0, 32'd7,  4'h8);
    vecs[21] = mk(ins(4'hE, 4'h1, 1, 4'd1, 4'd1, 4'd2), 32'hFFFF_FFFE, 4'h8, 1, 1, 0, 32'hFFFF_FFFE, 4'h8);
    vecs[22] = mk(ins(4'h3, 4'h0, 0, 4'd2, 4'd1, 4'd1),      32'h10, 4'h0, 1, 1, 0, 32'h10, 4'h8);
    vecs[23] = mk(ins(4'h6, 4'h0, 0, 4'd3, 4'd2, 4'd2),      32'h20, 4'h0, 0, 0, 0, 32'h20, 4'h8);
    vecs[24] = mk(ins(4'hE, 4'h0, 1, 4'd6, 4'd2, 4'd3),      32'hABC, 4'hF, 1, 1, 0, 32'hABC, 4'hF);
    vecs[25] = mk(ins(4'hE, 4'h0, 0, 4'd6, 4'd2, 4'd3),      32'h77, 4'h0, 1, 1, 0, 32'h77, 4'h0);
    vecs[26] = mk(ins(4'h2, 4'h0, 0, 4'd7, 4'd6, 4'd6),      32'd1,  4'h0, 0, 0, 0, 32'd1,  4'h0);
    vecs[27] = mk(ins(4'h7, 4'h0, 0, 4'd7, 4'd6, 4'd6),      32'd2,  4'h0, 1, 1, 0, 32'd2,  4'h0);

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; dbg_raddr = '0;
    alu_r = '0; {alu_n, alu_z, alu_c, alu_v} = 4'h0;
    exec_now = 1'b0; wb_now = 1'b0; acc_prev = 1'b0; post_wb = 1'b0;
    fork mon_loop(); join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_bus", {resp_data[27:0], resp_rd}, 32'd0);
    chk("rst_resp_flags", {30'd0, resp_wen, resp_err}, 32'd0);
    chk("rst_alu_inf", alu_inf, 32'd0);
    chk("rst_alu_ab", alu_a | alu_b, 32'd0);
    chk("rst_flags", 32'(flags_nzcv), 32'd0);
    rst = 1'b0;

    for (int i = 0; i <= 20; i++) run_one(i);

    begin
      int base;
      base = acc_count;
      issue(21, 1'b1);
      issue(22, 1'b1);
      issue(23, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("b2b_accepts", 32'(acc_count - base), 32'd3);
      chk("b2b_drained", 32'(sb_q.size()), 32'd0);
    end

    issue(24, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_flags", 32'(flags_nzcv), 32'd0);
    chk("abort_sb_cleared", 32'(sb_q.size()), 32'd0);
`ifdef ALU_ISSUE_PERF_EN
    chk("abort_perf", perf_issued | perf_skipped | perf_illegal, 32'd0);
`endif
    @(posedge clk); #1;
    chk("abort_no_late_resp", 32'(resp_valid), 32'd0);

    for (int i = 25; i <= 27; i++) run_one(i);

`ifdef ALU_ISSUE_PERF_EN
    chk("perf_issued", perf_issued, 32'(p_iss));
    chk("perf_skipped", perf_skipped, 32'(p_skip));
    chk("perf_illegal", perf_illegal, 32'(p_ill));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Multi-cycle issue/writeback sequencer on the producer side of the ALU instruction interface.
- Accepts 32-bit instruction words over a valid/ready handshake and reads operands from an internal register file.
- Drives the ALU's inf/a/b inputs, captures r and NZCV, then commits the result to the register file and the architectural flag register.
- Sits between the instruction source and the combinational ALU.

Parameters:
- NREGS, 16, register-file depth; the register index is 4 bits, so NREGS is at most 16.
- RST_FLAGS, 4'b0000, reset value of flags_nzcv.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction word valid
- in_ready  out  1  controller can accept a word
- in_instr  in  32  instruction word
- alu_inf  out  32  instruction word presented to the ALU
- alu_a  out  32  operand A to the ALU
- alu_b  out  32  operand B to the ALU
- alu_r  in  32  ALU result
- alu_n  in  1  ALU N flag
- alu_z  in  1  ALU Z flag
- alu_c  in  1  ALU C flag
- alu_v  in  1  ALU V flag
- resp_valid  out  1  one-cycle completion pulse
- resp_rd  out  4  destination register index
- resp_data  out  32  committed result
- resp_wen  out  1  register file was written
- resp_err  out  1  illegal opcode
- flags_nzcv  out  4  architectural flags {N,Z,C,V}
- dbg_raddr  in  4  debug read address
- dbg_rdata  out  32  combinational read of rf[dbg_raddr]

Behaviour:
- Instruction field layout:
  - [31:28] cond
  - [27:24] op
  - [23] S
  - [22:19] rd
  - [18:15] rn
  - [14:11] rm
  - [18:3] imm16 (MOVN only)
  - [10:6] shamt
  - [2:0] shift type
- Reset: state=IDLE; in_ready=1; alu_inf/alu_a/alu_b=0; all resp_* outputs=0; flags_nzcv=RST_FLAGS; every rf entry=0.
- Reset applied mid-operation aborts the instruction: no writeback and no resp_valid.
- FSM has three states: IDLE, EXEC, WB.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register alu_inf=in_instr, alu_a=rf[rn], alu_b=rf[rm], and latch rd/op/S/cond.
  - Evaluate cond against the current flags_nzcv and store the result as pass.
  - Go to EXEC.
- EXEC:
  - in_ready=0; ALU inputs are held stable.
  - At the clock edge, sample alu_r and alu_n/z/c/v into capture registers.
  - Go to WB.
- WB (lasts one cycle):
  - resp_valid=1, resp_rd=rd, resp_data=captured r.
  - Commits take effect at the end of the WB cycle; return to IDLE with in_ready=1.
  - Throughput is one instruction per 3 cycles; latency from accept edge to resp_valid is 2 cycles.
- Condition codes (ARM semantics):
  - 0000 EQ, 0001 NE, 0010 CS, 0011 CC, 0100 MI, 0101 PL, 0110 VS, 0111 VC
  - 1000 HI, 1001 LS, 1010 GE, 1011 LT, 1100 GT, 1101 LE
  - 1110 AL (always), 1111 never
- Commit rules:
  - op 0000–0111: if pass, write rf[rd]=r and set resp_wen=1. If S=1 as well, flags_nzcv takes the captured flags.
  - op 1000 (CMP): never writes the rf; resp_wen=0. If pass, flags are updated regardless of S.
  - op 1001–1111: resp_err=1, resp_wen=0, flags unchanged, and resp_data=0.
  - pass=0: resp_wen=0, flags unchanged, and resp_data=captured r (informational only).
- Hazards:
  - Instructions are serialised, so rf and flags are always committed before the next read.
  - A debug read of rf[rd] during WB returns the old value.
  - rd equal to rn or rm is legal.

Optional Feature:
- Macro ALU_ISSUE_PERF_EN.
- Defined:
  - Adds outputs perf_issued[31:0], perf_skipped[31:0] and perf_illegal[31:0], all reset to 0.
  - Each counter increments in WB: perf_issued for every instruction, perf_skipped when pass=0 and op is legal, perf_illegal when resp_err=1.
  - Counters wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Setup: rf preloaded to rf[1]=5 and rf[2]=7 via a MOVN sequence. Issue ADD AL, S=1, rd=3, rn=1, rm=2, shift=000; the model ALU returns r=12 with NZCV=0000. Required: resp_valid 2 cycles after accept, resp_data=12, resp_wen=1, rf[3]=12, flags=0000.
- Issue CMP AL with rn=rm=1 (ALU returns Z=1, C=1). Required: resp_wen=0, flags=0110. Then issue ADD EQ rd=4: rf[4] is written. Then ADD NE rd=5: resp_wen=0 and rf[5] is unchanged.
- Issue op=1010. Required: resp_err=1, resp_wen=0, flags unchanged, and in_ready returns after WB.
- Issue SUB AL with S=0 and ALU flags 1001. Required: rf written, flags_nzcv unchanged.
- Hold in_valid=1 with 3 back-to-back words. Required: in_ready is low in EXEC and WB, each word is accepted exactly once, resp_valid fires on cycles 2, 5 and 8.
- Assert rst during EXEC. Required: no resp_valid, rf[rd] unchanged, flags=RST_FLAGS, in_ready=1 the next cycle. With ALU_ISSUE_PERF_EN defined, all counters read 0.
